// File: rtl/vrf_pkg.sv
// Shared constants and types for the vector register file.
// The localparams mirror the default vrf_mport parameters.
package vrf_pkg;

    localparam int unsigned ELEMENTS   = 8;
    localparam int unsigned ELEN       = 32;
    localparam int unsigned NUM_REGS   = 32;
    localparam int unsigned VREG_AW    = $clog2(NUM_REGS);
    localparam int unsigned VREG_W     = ELEMENTS * ELEN;
    localparam int unsigned VREG_BYTES = VREG_W / 8;

    typedef logic [VREG_AW-1:0]               vreg_addr_t;
    typedef logic [ELEMENTS-1:0][ELEN-1:0]    vreg_t;
    typedef logic [VREG_BYTES-1:0]            vreg_be_t;

    typedef enum logic {
        CLR_IDLE,
        CLR_RUN
    } clr_state_e;

endpackage

// File: rtl/vrf_clear_seq.sv
// Clear sequencer: zeroes one register per cycle after reset or on request.
module vrf_clear_seq
    import vrf_pkg::*;
#(
    parameter int unsigned NREGS = 32,
    parameter int unsigned AW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          init_req,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr,
    output logic          init_busy
);

    localparam logic [AW-1:0] LastPtr = AW'(NREGS - 1);

    clr_state_e    state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= CLR_RUN;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        clr_we  = 1'b0;
        case (state_q)
            CLR_IDLE: begin
                if (init_req) begin
                    state_d = CLR_RUN;
                    ptr_d   = '0;
                end
            end
            CLR_RUN: begin
                // init_req is deliberately ignored here: no restart or extension.
                clr_we = 1'b1;
                ptr_d  = ptr_q + 1'b1;
                if (ptr_q == LastPtr) begin
                    state_d = CLR_IDLE;
                end
            end
            default: state_d = CLR_IDLE;
        endcase
    end

    assign clr_addr  = ptr_q;
    assign init_busy = (state_q == CLR_RUN);

endmodule

// File: rtl/vrf_mport.sv
// Multi-port vector register file: two prioritised byte-enable write ports,
// registered write-first reads, mask read port and hardware clear.
module vrf_mport #(
    parameter int unsigned ELEMENTS = vrf_pkg::ELEMENTS,
    parameter int unsigned ELEN     = vrf_pkg::ELEN,
    parameter int unsigned NUM_REGS = vrf_pkg::NUM_REGS,
    parameter int unsigned RD_PORTS = 3,
    parameter int unsigned AW       = $clog2(NUM_REGS)
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   init_req,
    output logic                                   init_busy,
    input  logic [RD_PORTS-1:0]                    rd_en,
    input  logic [RD_PORTS-1:0][AW-1:0]            rd_addr,
    output logic [RD_PORTS-1:0][ELEMENTS*ELEN-1:0] rd_data,
    input  logic [AW-1:0]                          mask_src,
    output logic [ELEMENTS-1:0]                    mask,
    input  logic [ELEMENTS-1:0]                    wa_en,
    input  logic [ELEMENTS*ELEN/8-1:0]             wa_be,
    input  logic [AW-1:0]                          wa_addr,
    input  logic [ELEMENTS*ELEN-1:0]               wa_data,
    input  logic [ELEMENTS-1:0]                    wb_en,
    input  logic [ELEMENTS*ELEN/8-1:0]             wb_be,
    input  logic [AW-1:0]                          wb_addr,
    input  logic [ELEMENTS*ELEN-1:0]               wb_data,
    output logic                                   wb_conflict
);

    localparam int unsigned W   = ELEMENTS * ELEN;
    localparam int unsigned NB  = W / 8;
    localparam int unsigned BPE = ELEN / 8;

    logic [W-1:0] mem [NUM_REGS];

    logic          clr_we;
    logic [AW-1:0] clr_addr;

    vrf_clear_seq #(
        .NREGS (NUM_REGS),
        .AW    (AW)
    ) u_clear_seq (
        .clk       (clk),
        .rst_n     (rst_n),
        .init_req  (init_req),
        .clr_we    (clr_we),
        .clr_addr  (clr_addr),
        .init_busy (init_busy)
    );

    // Per-byte write masks, already gated off while clearing.
    logic [NB-1:0] wa_mask, wb_mask;
    logic          conflict;

    always_comb begin
        wa_mask = '0;
        wb_mask = '0;
        for (int b = 0; b < NB; b++) begin
            wa_mask[b] = wa_be[b] & wa_en[b/BPE] & ~init_busy;
            wb_mask[b] = wb_be[b] & wb_en[b/BPE] & ~init_busy;
        end
        conflict = (wa_addr == wb_addr) && |(wa_mask & wb_mask);
    end

    // Register content after this edge's writes; port A overrides port B.
    function automatic logic [W-1:0] merge_wr(
        input logic [W-1:0]  old,
        input logic [AW-1:0] addr,
        input logic [AW-1:0] a_addr,
        input logic [NB-1:0] a_mask,
        input logic [W-1:0]  a_data,
        input logic [AW-1:0] b_addr,
        input logic [NB-1:0] b_mask,
        input logic [W-1:0]  b_data
    );
        logic [W-1:0] r;
        r = old;
        for (int b = 0; b < NB; b++) begin
            if (addr == a_addr && a_mask[b]) begin
                r[b*8 +: 8] = a_data[b*8 +: 8];
            end else if (addr == b_addr && b_mask[b]) begin
                r[b*8 +: 8] = b_data[b*8 +: 8];
            end
        end
        return r;
    endfunction

    logic [W-1:0]               wa_word, wb_word, mask_word;
    logic [RD_PORTS-1:0][W-1:0] rd_next;
    logic [ELEMENTS-1:0]        mask_next;

    always_comb begin
        wa_word   = merge_wr(mem[wa_addr], wa_addr, wa_addr, wa_mask, wa_data,
                             wb_addr, wb_mask, wb_data);
        wb_word   = merge_wr(mem[wb_addr], wb_addr, wa_addr, wa_mask, wa_data,
                             wb_addr, wb_mask, wb_data);
        mask_word = merge_wr(mem[mask_src], mask_src, wa_addr, wa_mask, wa_data,
                             wb_addr, wb_mask, wb_data);
        rd_next   = '0;
        for (int p = 0; p < RD_PORTS; p++) begin
            rd_next[p] = merge_wr(mem[rd_addr[p]], rd_addr[p], wa_addr, wa_mask, wa_data,
                                  wb_addr, wb_mask, wb_data);
        end
        mask_next = '0;
        for (int k = 0; k < ELEMENTS; k++) begin
            mask_next[k] = mask_word[k*ELEN];
        end
    end

    // Both ports write the fully merged word, so same-address writes agree.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else begin
            if (|wb_mask) begin
                mem[wb_addr] <= wb_word;
            end
            if (|wa_mask) begin
                mem[wa_addr] <= wa_word;
            end
        end
    end

    logic [RD_PORTS-1:0][W-1:0] rd_q;
    logic [ELEMENTS-1:0]        mask_q;
    logic                       conflict_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_q       <= '0;
            mask_q     <= '0;
            conflict_q <= 1'b0;
        end else if (init_busy) begin
            rd_q       <= '0;
            mask_q     <= '0;
            conflict_q <= 1'b0;
        end else begin
            for (int p = 0; p < RD_PORTS; p++) begin
                if (rd_en[p]) begin
                    rd_q[p] <= rd_next[p];
                end
            end
            mask_q     <= mask_next;
            conflict_q <= conflict;
        end
    end

    assign rd_data     = rd_q;
    assign mask        = mask_q;
    assign wb_conflict = conflict_q;

endmodule

// File: tb/tb_vrf_mport.sv
// Directed, table-driven bench for vrf_mport with hand-computed expectations.
module tb_vrf_mport;

    localparam int W = 256;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             init_req;
    logic             init_busy;
    logic [2:0]       rd_en;
    logic [2:0][4:0]  rd_addr;
    logic [2:0][W-1:0] rd_data;
    logic [4:0]       mask_src;
    logic [7:0]       mask;
    logic [7:0]       wa_en;
    logic [31:0]      wa_be;
    logic [4:0]       wa_addr;
    logic [W-1:0]     wa_data;
    logic [7:0]       wb_en;
    logic [31:0]      wb_be;
    logic [4:0]       wb_addr;
    logic [W-1:0]     wb_data;
    logic             wb_conflict;

    always #5 clk = ~clk;

    vrf_mport dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .init_req    (init_req),
        .init_busy   (init_busy),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .mask_src    (mask_src),
        .mask        (mask),
        .wa_en       (wa_en),
        .wa_be       (wa_be),
        .wa_addr     (wa_addr),
        .wa_data     (wa_data),
        .wb_en       (wb_en),
        .wb_be       (wb_be),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .wb_conflict (wb_conflict)
    );

    typedef struct {
        string        name;
        logic [7:0]   wa_en;
        logic [31:0]  wa_be;
        logic [4:0]   wa_addr;
        logic [W-1:0] wa_data;
        logic [7:0]   wb_en;
        logic [31:0]  wb_be;
        logic [4:0]   wb_addr;
        logic [W-1:0] wb_data;
        logic [2:0]   rd_en;
        logic [4:0]   rd_addr;
        logic [W-1:0] exp_rd;
        logic         exp_conf;
    } vec_t;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic idle_wr();
        wa_en = '0; wa_be = '0; wa_addr = '0; wa_data = '0;
        wb_en = '0; wb_be = '0; wb_addr = '0; wb_data = '0;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (init_busy && n < 200) begin
            n++;
            step();
        end
    endtask

    vec_t vecs[8];
    int   cnt, bad_rd, bad_conf;

    initial begin
        vecs[0] = '{"a_v5_full", 8'hFF, 32'hFFFF_FFFF, 5'd5, {8{32'hAAAA_AAAA}},
                    8'h00, 32'h0, 5'd0, '0, 3'b111, 5'd5, {8{32'hAAAA_AAAA}}, 1'b0};
        vecs[1] = '{"b_v5_e2_hold", 8'h00, 32'h0, 5'd0, '0,
                    8'h04, 32'h3333_3333, 5'd5, {8{32'h1234_5678}}, 3'b000, 5'd5,
                    {8{32'hAAAA_AAAA}}, 1'b0};
        vecs[2] = '{"rd_v5_merge", 8'h00, 32'h0, 5'd0, '0, 8'h00, 32'h0, 5'd0, '0,
                    3'b111, 5'd5,
                    {{5{32'hAAAA_AAAA}}, 32'hAAAA_5678, {2{32'hAAAA_AAAA}}}, 1'b0};
        vecs[3] = '{"disjoint_v5", 8'h01, 32'hFFFF_FFFF, 5'd5, {8{32'hC0C0_C0C0}},
                    8'h02, 32'hFFFF_FFFF, 5'd5, {8{32'h0B0B_0B0B}}, 3'b111, 5'd5,
                    {{5{32'hAAAA_AAAA}}, 32'hAAAA_5678, 32'h0B0B_0B0B, 32'hC0C0_C0C0}, 1'b0};
        vecs[4] = '{"byte_coll_v6", 8'hFF, 32'h0000_0001, 5'd6, {8{32'h1111_1111}},
                    8'hFF, 32'h0000_00F3, 5'd6, {8{32'h2222_2222}}, 3'b111, 5'd6,
                    {{6{32'h0}}, 32'h2222_2222, 32'h0000_2211}, 1'b1};
        vecs[5] = '{"diff_regs", 8'hFF, 32'hFFFF_FFFF, 5'd1, {8{32'h0101_0101}},
                    8'hFF, 32'hFFFF_FFFF, 5'd2, {8{32'h0202_0202}}, 3'b111, 5'd2,
                    {8{32'h0202_0202}}, 1'b0};
        vecs[6] = '{"b_en_off_v8", 8'hFF, 32'hFFFF_FFFF, 5'd8, {8{32'h0808_0808}},
                    8'h00, 32'hFFFF_FFFF, 5'd8, {8{32'hFFFF_FFFF}}, 3'b111, 5'd8,
                    {8{32'h0808_0808}}, 1'b0};
        vecs[7] = '{"rd_v1", 8'h00, 32'h0, 5'd0, '0, 8'h00, 32'h0, 5'd0, '0,
                    3'b111, 5'd1, {8{32'h0101_0101}}, 1'b0};

        rst_n = 1'b0; init_req = 1'b0; rd_en = '0; rd_addr = '0; mask_src = '0;
        idle_wr();

        // Reset and initial clear; a dual-port write to v0 mid-clear must vanish.
        @(negedge clk);
        step();
        step();
        chk("rst_busy", W'(init_busy), W'(1));
        chk("rst_rd0", rd_data[0], '0);
        chk("rst_mask", W'(mask), '0);
        chk("rst_conf", W'(wb_conflict), '0);
        rst_n = 1'b1;
        rd_en = 3'b111;
        cnt = 0; bad_rd = 0; bad_conf = 0;
        while (init_busy && cnt < 200) begin
            cnt++;
            if (rd_data != '0) bad_rd++;
            if (wb_conflict) bad_conf++;
            if (cnt == 6) begin
                wa_en = 8'hFF; wa_be = '1; wa_addr = 5'd0; wa_data = {8{32'h5A5A_5A5A}};
                wb_en = 8'hFF; wb_be = '1; wb_addr = 5'd0; wb_data = {8{32'hA5A5_A5A5}};
            end else begin
                idle_wr();
            end
            step();
        end
        idle_wr();
        chk("busy_len_rst", W'(cnt), W'(32));
        chk("busy_rd_zero", W'(bad_rd), '0);
        chk("busy_conf_zero", W'(bad_conf), '0);
        for (int r = 0; r < 32; r++) begin
            rd_addr = {3{5'(r)}};
            step();
            chk($sformatf("clr_v%0d", r), rd_data[0] | rd_data[1] | rd_data[2], '0);
        end

        for (int i = 0; i < 8; i++) begin
            wa_en = vecs[i].wa_en; wa_be = vecs[i].wa_be;
            wa_addr = vecs[i].wa_addr; wa_data = vecs[i].wa_data;
            wb_en = vecs[i].wb_en; wb_be = vecs[i].wb_be;
            wb_addr = vecs[i].wb_addr; wb_data = vecs[i].wb_data;
            rd_en = vecs[i].rd_en; rd_addr = {3{vecs[i].rd_addr}};
            step();
            for (int p = 0; p < 3; p++) begin
                chk($sformatf("%s_rd%0d", vecs[i].name, p), rd_data[p], vecs[i].exp_rd);
            end
            chk($sformatf("%s_conf", vecs[i].name), W'(wb_conflict), W'(vecs[i].exp_conf));
        end
        idle_wr(); rd_en = '0;

        // Collision on v7: A wins element 0, B keeps element 1, one-cycle pulse.
        wa_en = 8'h01; wa_be = '1; wa_addr = 5'd7; wa_data = {8{32'h1111_1111}};
        wb_en = 8'h03; wb_be = '1; wb_addr = 5'd7;
        wb_data = {{6{32'h0}}, 32'h3333_3333, 32'h2222_2222};
        step();
        chk("coll_conf_hi", W'(wb_conflict), W'(1));
        idle_wr(); rd_en = 3'b111; rd_addr = {3{5'd7}};
        step();
        chk("coll_conf_lo", W'(wb_conflict), '0);
        chk("coll_v7", rd_data[0], {{6{32'h0}}, 32'h3333_3333, 32'h1111_1111});

        // Bypass on all ports, then hold with rd_en low while v3 is overwritten.
        wa_en = 8'hFF; wa_be = '1; wa_addr = 5'd3; wa_data = {8{32'hDEAD_BEEF}};
        rd_en = 3'b111; rd_addr = {3{5'd3}};
        step();
        for (int p = 0; p < 3; p++) chk($sformatf("byp_rd%0d", p), rd_data[p], {8{32'hDEAD_BEEF}});
        wa_data = '0; rd_en = '0;
        step();
        for (int p = 0; p < 3; p++) chk($sformatf("hold_rd%0d", p), rd_data[p], {8{32'hDEAD_BEEF}});
        idle_wr(); rd_en = 3'b111;
        rd_addr[0] = 5'd3; rd_addr[1] = 5'd7; rd_addr[2] = 5'd5;
        step();
        chk("sep_rd0", rd_data[0], '0);
        chk("sep_rd1", rd_data[1], {{6{32'h0}}, 32'h3333_3333, 32'h1111_1111});
        chk("sep_rd2", rd_data[2],
            {{5{32'hAAAA_AAAA}}, 32'hAAAA_5678, 32'h0B0B_0B0B, 32'hC0C0_C0C0});
        rd_en = '0;

        // Mask with same-cycle bypass, then a different mask source.
        wa_en = 8'hFF; wa_be = '1; wa_addr = 5'd0;
        wa_data = {32'hFFFF_FFFE, 32'h1, 32'hFFFF_FFFE, 32'hFFFF_FFFE,
                   32'h1, 32'h1, 32'hFFFF_FFFE, 32'h1};
        mask_src = 5'd0;
        step();
        chk("mask_v0", W'(mask), W'(8'b0100_1101));
        idle_wr(); mask_src = 5'd5;
        step();
        chk("mask_v5", W'(mask), W'(8'b0000_0010));

        // init_req during busy must not extend the clear.
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        cnt = 0;
        while (init_busy && cnt < 200) begin
            cnt++;
            init_req = (cnt == 10);
            step();
        end
        init_req = 1'b0;
        chk("busy_len_req", W'(cnt), W'(32));

        // Reset mid-clear restarts the full sequence.
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) step();
        chk("busy_mid", W'(init_busy), W'(1));
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        count_busy(cnt);
        chk("busy_len_restart", W'(cnt), W'(32));

        // Idle init_req clears a written register.
        wa_en = 8'hFF; wa_be = '1; wa_addr = 5'd9; wa_data = {8{32'h9999_9999}};
        rd_en = 3'b001; rd_addr = {3{5'd9}};
        step();
        chk("v9_written", rd_data[0], {8{32'h9999_9999}});
        idle_wr(); rd_en = '0;
        init_req = 1'b1;
        step();
        init_req = 1'b0;
        chk("req_busy", W'(init_busy), W'(1));
        count_busy(cnt);
        chk("busy_len_idle_req", W'(cnt), W'(32));
        rd_en = 3'b001;
        step();
        chk("v9_cleared", rd_data[0], '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
